// File: rtl/wts_i2s_tx.sv
// Stereo I2S transmitter: 2x15-bit samples to 16-bit slots with an internal bit/word clock prescaler.
// Define WTS_I2S_LJ_EN for left-justified framing (no one-bit data delay); default is standard I2S.
module wts_i2s_tx #(
    parameter int unsigned BCLK_HALF = 7
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        enable,
    input  logic [14:0] left_in,
    input  logic [14:0] right_in,
    output logic        sample_ack,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_data
);

    localparam int unsigned PRE_W    = 8;
    localparam int unsigned SLOT_W   = 5;
    localparam int unsigned FRAME_W  = 32;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(BCLK_HALF - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = '1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    state_e               state_q, state_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 bclk_q, bclk_d;
    logic                 data_q, data_d;
    logic                 ack_q, ack_d;

    logic                 tick;
    logic                 fall;
    logic [SLOT_W-1:0]    slot_nx;

    assign tick    = (pre_q == PRE_LAST);
    assign fall    = tick && bclk_q;
    assign slot_nx = slot_q + SLOT_W'(1);

    // Next-state: prescaler, slot counter, frame capture and serial bit select
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        slot_d  = slot_q;
        frame_d = frame_q;
        bclk_d  = bclk_q;
        data_d  = data_q;
        ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pre_d  = '0;
                slot_d = SLOT_LAST;
                bclk_d = 1'b0;
                data_d = 1'b0;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                pre_d = tick ? '0 : pre_q + PRE_W'(1);
                if (tick) begin
                    bclk_d = ~bclk_q;
                end
                if (fall) begin
                    if (slot_q == SLOT_LAST) begin
                        if (enable) begin
                            frame_d = {left_in, 1'b0, right_in, 1'b0};
                            slot_d  = '0;
                            ack_d   = 1'b1;
`ifdef WTS_I2S_LJ_EN
                            data_d  = left_in[14];
`else
                            data_d  = 1'b0;
`endif
                        end else begin
                            state_d = ST_IDLE;
                            pre_d   = '0;
                            slot_d  = SLOT_LAST;
                            bclk_d  = 1'b0;
                            data_d  = 1'b0;
                        end
                    end else begin
                        slot_d = slot_nx;
                        // Frame bit k lives at frame_q[31-k] == frame_q[~k]
`ifdef WTS_I2S_LJ_EN
                        data_d = frame_q[~slot_nx];
`else
                        data_d = frame_q[~slot_q];
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            slot_q  <= SLOT_LAST;
            frame_q <= '0;
            bclk_q  <= 1'b0;
            data_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            slot_q  <= slot_d;
            frame_q <= frame_d;
            bclk_q  <= bclk_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    assign sample_ack = ack_q;
    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = slot_q[SLOT_W-1];
    assign i2s_data   = data_q;

endmodule

// File: tb/tb_wts_i2s_tx.sv
// Scoreboard bench for wts_i2s_tx at BCLK_HALF = 2, 1 and 255, with a reference model of frame timing and words.
module tb_wts_i2s_tx;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   phase2 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sample pair for the k-th frame of an instance: directed patterns first, then random
    function automatic logic [29:0] pick(input int k);
        logic [14:0] a;
        logic [14:0] b;
        a = 15'($urandom);
        b = 15'($urandom);
        case (k)
            0: begin a = 15'h3FFF; b = 15'h4000; end
            1: begin a = 15'h2AAA; b = 15'h4000; end
            2: a = 15'h7FFF;
            3: a = 15'h0000;
            default: ;
        endcase
        return {a, b};
    endfunction

    // Bits seen on rising bclk from slot 0 to slot 31 for a given frame word
    function automatic logic [31:0] wire_bits(input logic [31:0] w);
`ifdef WTS_I2S_LJ_EN
        return w;
`else
        return {1'b0, w[31:1]};
`endif
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int PI = (g == 0) ? 2 : ((g == 1) ? 1 : 255);
        localparam int NF0 = (PI > 100) ? 2 : 6;
        localparam int RUNS = (PI > 100) ? 1 : 2;

        logic        en;
        logic [14:0] lin;
        logic [14:0] rin;
        logic        ack;
        logic        bclk;
        logic        lr;
        logic        dat;
        bit          done;
        bit          mid;
        int          e0;
        logic [31:0] exp_q[$];
        int          ack_q[$];

        bit          prev_b;
        bit          prev_lr;
        bit          active;
        int          idx;
        logic [31:0] sh;

        wts_i2s_tx #(.BCLK_HALF(PI)) u_dut (
            .clk       (clk),
            .nreset    (nreset),
            .enable    (en),
            .left_in   (lin),
            .right_in  (rin),
            .sample_ack(ack),
            .i2s_bclk  (bclk),
            .i2s_lrclk (lr),
            .i2s_data  (dat)
        );

        // Monitor: edge timing, ack timing and reassembled frame words against the scoreboard
        always @(negedge clk) begin
            prev_b  <= bclk;
            prev_lr <= lr;
            if (!nreset) begin
                active <= 1'b0;
            end else begin
                if (ack === 1'b1) begin
                    if (ack_q.size() == 0) check($sformatf("P%0d_ack_unexpected", PI), 64'd1, 64'd0);
                    else check($sformatf("P%0d_ack_cycle", PI), 64'(cyc), 64'(ack_q.pop_front()));
                end
                if (bclk !== prev_b)
                    check($sformatf("P%0d_bclk_edge_phase", PI),
                          64'((cyc - e0) % (2 * PI)), (bclk === 1'b1) ? 64'(PI) : 64'd0);
                if (prev_lr && lr === 1'b0) begin
                    active <= 1'b1;
                    idx    <= 0;
                end else if (active && bclk === 1'b1 && !prev_b) begin
                    check($sformatf("P%0d_lrclk_slot%0d", PI, idx), 64'(lr), 64'(idx >= 16));
                    sh  <= {sh[30:0], dat};
                    idx <= idx + 1;
                    if (idx == 31) begin
                        active <= 1'b0;
                        if (exp_q.size() == 0) check($sformatf("P%0d_word_unexpected", PI), 64'd1, 64'd0);
                        else check($sformatf("P%0d_frame_word", PI), 64'({sh[30:0], dat}),
                                   64'(wire_bits(exp_q.pop_front())));
                    end
                end
            end
        end

        // Stimulus: frames with mid-frame input changes, graceful stop, restart
        initial begin : stim
            int k;
            int cap;
            int nf;
            logic [29:0] pr;
            en = 1'b0; lin = '0; rin = '0; e0 = 0; k = 0; cap = 0;
            wait (nreset === 1'b1);
            for (int r = 0; r < RUNS; r++) begin
                @(negedge clk);
                e0 = cyc + 1;
                pr = pick(k);
                k++;
                lin = pr[29:15];
                rin = pr[14:0];
                exp_q.push_back({lin, 1'b0, rin, 1'b0});
                ack_q.push_back(e0 + 2 * PI);
                en = 1'b1;
                nf = (r == 0) ? NF0 : 2;
                for (int f = 0; f < nf; f++) begin
                    cap = e0 + 2 * PI + f * 64 * PI;
                    while (cyc < cap + 10 * PI + 1) @(negedge clk);
                    pr  = pick(k);
                    lin = pr[29:15];
                    rin = pr[14:0];
                    if (f < nf - 1) begin
                        k++;
                        exp_q.push_back({lin, 1'b0, rin, 1'b0});
                        ack_q.push_back(cap + 64 * PI);
                    end else begin
                        while (cyc < cap + 20 * PI + 1) @(negedge clk);
                        en = 1'b0;
                    end
                end
                while (cyc < cap + 66 * PI + 10) @(negedge clk);
                check($sformatf("P%0d_idle_bclk", PI), 64'(bclk), 64'd0);
                check($sformatf("P%0d_idle_lrclk", PI), 64'(lr), 64'd1);
                check($sformatf("P%0d_idle_data", PI), 64'(dat), 64'd0);
                check($sformatf("P%0d_words_left", PI), 64'(exp_q.size()), 64'd0);
                check($sformatf("P%0d_acks_left", PI), 64'(ack_q.size()), 64'd0);
            end
            done = 1'b1;
            if (g == 0) begin
                wait (phase2);
                @(negedge clk);
                e0  = cyc + 1;
                lin = 15'($urandom);
                rin = 15'($urandom);
                ack_q.push_back(e0 + 2 * PI);
                en = 1'b1;
                while (cyc < e0 + 26 * PI + 1) @(negedge clk);
                mid = 1'b1;
                wait (nreset === 1'b0);
                en = 1'b0;
            end
        end
    end

    initial begin : main
        int dev;
        bit all_done;
        repeat (3) @(negedge clk);
        check("reset_bclk", 64'(g_inst[0].bclk), 64'd0);
        check("reset_lrclk", 64'(g_inst[0].lr), 64'd1);
        check("reset_data", 64'(g_inst[0].dat), 64'd0);
        check("reset_ack", 64'(g_inst[0].ack), 64'd0);
        nreset = 1'b1;

        all_done = 1'b0;
        for (int c = 0; c < 60000; c++) begin
            all_done = g_inst[0].done && g_inst[1].done && g_inst[2].done;
            if (all_done) break;
            @(negedge clk);
        end
        check("all_runs_done", 64'(all_done), 64'd1);

        phase2 = 1'b1;
        for (int c = 0; c < 500 && !g_inst[0].mid; c++) @(negedge clk);
        check("midframe_reached", 64'(g_inst[0].mid), 64'd1);
        check("midframe_running_lrclk", 64'(g_inst[0].lr), 64'd0);
        #2 nreset = 1'b0;
        #1;
        check("async_reset_bclk", 64'(g_inst[0].bclk), 64'd0);
        check("async_reset_lrclk", 64'(g_inst[0].lr), 64'd1);
        check("async_reset_data", 64'(g_inst[0].dat), 64'd0);
        check("async_reset_ack", 64'(g_inst[0].ack), 64'd0);
        repeat (3) @(negedge clk);
        nreset = 1'b1;

        dev = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({g_inst[0].bclk, g_inst[0].lr, g_inst[0].dat, g_inst[0].ack} !== 4'b0100) dev++;
        end
        check("post_reset_idle_1000", 64'(dev), 64'd0);
        check("post_reset_acks_left", 64'(g_inst[0].ack_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
